digital_filter: RTL and testbench

DIGITAL_FILTER -- requirements
Module: digital_filter

---
 rtl/digital_filter.sv | 67 ++++++
 tb/tb_digital_filter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/digital_filter.sv
// Direct-form FIR filter: NUM_TAPS-deep sample delay line, full-precision
// multiply-accumulate over all taps, arithmetic scaling by COEFF_WIDTH-1 bits
// and saturation to DATA_WIDTH. Output is registered; coefficients are live.
module digital_filter #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
  output logic [DATA_WIDTH-1:0]           data_out
);

  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0]  x [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] c;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       shifted;
  logic        [DATA_WIDTH-1:0]  sat_val;

  // Sum of coeff[k]*x[k] over the current (pre-edge) delay line contents.
  always_comb begin
    acc  = '0;
    c    = '0;
    prod = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      c    = coeff[k*COEFF_WIDTH +: COEFF_WIDTH];
      prod = PROD_W'(c) * PROD_W'(x[k]);
      acc  = acc + ACC_W'(prod);
    end
  end

  // Scale back from Q1.(COEFF_WIDTH-1) by flooring shift, then clamp.
  always_comb begin
    shifted = acc >>> (COEFF_WIDTH - 1);
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN)
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  // Delay line shift and output register; reset clears all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++)
        x[k] <= '0;
      data_out <= '0;
    end else begin
      x[0] <= data_in;
      for (int unsigned k = 1; k < NUM_TAPS; k++)
        x[k] <= x[k-1];
      data_out <= sat_val;
    end
  end

endmodule

// File: tb/tb_digital_filter.sv
// Directed-vector bench for digital_filter with default parameters.
module tb_digital_filter;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      data_in;
  logic [NT*CW-1:0]   coeff;
  logic [DW-1:0]      data_out;

  int n_total = 0;
  int n_bad   = 0;

  digital_filter #(
    .DATA_WIDTH  (DW),
    .COEFF_WIDTH (CW),
    .NUM_TAPS    (NT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .coeff    (coeff),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs may be changed right after return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tap(input int k, input logic [CW-1:0] v);
    coeff[k*CW +: CW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    data_in = '0;
    coeff   = '0;
    step();
    step();
    check("reset_state", data_out, 16'h0000);

    // Streaming then mid-stream reset, taps 0 and 1 at half gain.
    rst = 1'b0;
    set_tap(0, 16'h4000);
    set_tap(1, 16'h4000);
    data_in = 16'h1000;
    step();
    check("stream_e1", data_out, 16'h0000);
    step();
    check("stream_e2", data_out, 16'h0800);
    step();
    check("stream_e3", data_out, 16'h1000);
    rst = 1'b1;
    step();
    check("mid_reset", data_out, 16'h0000);
    step();
    step();
    check("held_reset", data_out, 16'h0000);
    rst     = 1'b0;
    data_in = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_reset_%0d", i), data_out, 16'h0000);
    end

    // Half-gain impulse through tap 0.
    coeff = '0;
    set_tap(0, 16'h4000);
    do_reset();
    data_in = 16'h4000;
    step();
    check("imp_t0", data_out, 16'h0000);
    data_in = '0;
    step();
    check("imp_t0p1", data_out, 16'h2000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("imp_tail_%0d", i), data_out, 16'h0000);
    end

    // Near-unity gain truncates toward negative infinity.
    coeff = '0;
    set_tap(0, 16'h7FFF);
    data_in = 16'd1000;
    step(); step(); step();
    check("trunc_pos", data_out, 16'd999);
    data_in = 16'hFC18;
    step(); step(); step();
    check("trunc_neg", data_out, 16'hFC18);

    // Impulse appears only through tap 5, six edges after capture.
    coeff = '0;
    set_tap(5, 16'h4000);
    do_reset();
    data_in = 16'h2000;
    step();
    check("tap5_e0", data_out, 16'h0000);
    data_in = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("tap5_e%0d", i), data_out, (i == 6) ? 16'h1000 : 16'h0000);
    end

    // Saturation with every tap near unity.
    for (int k = 0; k < NT; k++)
      set_tap(k, 16'h7FFF);
    data_in = 16'h7FFF;
    for (int i = 0; i < 34; i++)
      step();
    check("sat_pos", data_out, 16'h7FFF);
    data_in = 16'h8000;
    for (int i = 0; i < 34; i++)
      step();
    check("sat_neg", data_out, 16'h8000);

    // Coefficient change takes effect on the next edge only.
    coeff = '0;
    set_tap(0, 16'h4000);
    data_in = 16'h4000;
    step(); step(); step();
    check("coef_before", data_out, 16'h2000);
    set_tap(0, 16'h2000);
    #2;
    check("coef_no_edge", data_out, 16'h2000);
    step();
    check("coef_after", data_out, 16'h1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
